rf_wb_sched: RTL and testbench



---
 rtl/rf_wb_sched_if.sv | 37 +++
 rtl/rf_wb_sched.sv | 171 +++++++++++++++++
 tb/tb_rf_wb_sched.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/rf_wb_sched_if.sv
// Write-back scheduler bus: execute-unit write-back requests, regfile write
// ports, and the issue-stage scoreboard lookup.
//   master : execute units / issue stage (drive requests, issue and read addresses)
//   slave  : rf_wb_sched (drives grants, write ports and busy flags)
// Signals:
//   req_valid[3], req_addr[3*addr_w], req_data[3*data_w], req_ready[3]
//   wr1_addr/wr1_data, wr2_addr/wr2_data (address 0 = no write)
//   iss_valid, iss_addr, rs1_addr, rs2_addr, rs1_busy, rs2_busy
interface rf_wb_sched_if #(
    parameter int unsigned addr_w = 5,
    parameter int unsigned data_w = 32
) ();
    logic [2:0]          req_valid;
    logic [3*addr_w-1:0] req_addr;
    logic [3*data_w-1:0] req_data;
    logic [2:0]          req_ready;
    logic [addr_w-1:0]   wr1_addr;
    logic [data_w-1:0]   wr1_data;
    logic [addr_w-1:0]   wr2_addr;
    logic [data_w-1:0]   wr2_data;
    logic                iss_valid;
    logic [addr_w-1:0]   iss_addr;
    logic [addr_w-1:0]   rs1_addr;
    logic [addr_w-1:0]   rs2_addr;
    logic                rs1_busy;
    logic                rs2_busy;

    modport master (
        output req_valid, req_addr, req_data, iss_valid, iss_addr, rs1_addr, rs2_addr,
        input  req_ready, wr1_addr, wr1_data, wr2_addr, wr2_data, rs1_busy, rs2_busy
    );

    modport slave (
        input  req_valid, req_addr, req_data, iss_valid, iss_addr, rs1_addr, rs2_addr,
        output req_ready, wr1_addr, wr1_data, wr2_addr, wr2_data, rs1_busy, rs2_busy
    );
endinterface

// File: rtl/rf_wb_sched.sv
// Write-back scheduler: round-robin arbitration of three write-back requesters
// (0 = ALU, 1 = LSU, 2 = CSR/MUL) onto two registered regfile write ports, plus
// an optional pending-write scoreboard for RAW hazard detection.
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - rf_wb_sched_if.slave (requests/grants, write ports, scoreboard lookup)
// Configuration:
//   RF_WB_SB_EN defined   - scoreboard built; rs1_busy/rs2_busy reflect pending writes
//   RF_WB_SB_EN undefined - no scoreboard; rs1_busy = rs2_busy = 0, issue inputs ignored
module rf_wb_sched #(
    parameter int unsigned addr_w = 5,
    parameter int unsigned data_w = 32
) (
    input  logic          clk,
    input  logic          rst,
    rf_wb_sched_if.slave  bus
);
    localparam int unsigned n_req = 3;

    // Priority walk position k (0..2) starting from pointer p, modulo 3.
    function automatic logic [1:0] rr_idx(input logic [1:0] p, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, p} + {1'b0, k};
        return (s >= 3'd3) ? 2'(s - 3'd3) : 2'(s);
    endfunction

    logic [addr_w-1:0] a    [n_req];
    logic [data_w-1:0] d    [n_req];
    logic [n_req-1:0]  cand;
    logic [n_req-1:0]  null_c;

    logic [1:0]        ptr_q;
    logic [1:0]        ptr_d;
    logic [n_req-1:0]  gnt_c;
    logic              p1_hit;
    logic [1:0]        p1_idx;
    logic [addr_w-1:0] p1_addr;
    logic [data_w-1:0] p1_data;
    logic              p2_hit;
    logic [1:0]        p2_idx;
    logic [addr_w-1:0] p2_addr;
    logic [data_w-1:0] p2_data;

    logic [addr_w-1:0] wr1_addr_q;
    logic [data_w-1:0] wr1_data_q;
    logic [addr_w-1:0] wr2_addr_q;
    logic [data_w-1:0] wr2_data_q;

    // Unpack per-requester slices; address 0 is a null write needing no port.
    always_comb begin
        for (int i = 0; i < int'(n_req); i++) begin
            a[i]      = bus.req_addr[i*addr_w +: addr_w];
            d[i]      = bus.req_data[i*data_w +: data_w];
            cand[i]   = bus.req_valid[i] && (a[i] != '0);
            null_c[i] = bus.req_valid[i] && (a[i] == '0);
        end
    end

    // Round-robin port assignment; a same-address loser stalls while a later
    // candidate may still claim port 2.
    always_comb begin
        logic [1:0] idx;
        logic [1:0] last;
        gnt_c   = '0;
        p1_hit  = 1'b0;
        p1_idx  = '0;
        p1_addr = '0;
        p1_data = '0;
        p2_hit  = 1'b0;
        p2_idx  = '0;
        p2_addr = '0;
        p2_data = '0;
        idx     = '0;
        last    = '0;
        ptr_d   = ptr_q;
        for (int k = 0; k < int'(n_req); k++) begin
            idx = rr_idx(ptr_q, 2'(k));
            if (cand[idx]) begin
                if (!p1_hit) begin
                    p1_hit     = 1'b1;
                    p1_idx     = idx;
                    p1_addr    = a[idx];
                    p1_data    = d[idx];
                    gnt_c[idx] = 1'b1;
                end else if (!p2_hit && (a[idx] != p1_addr)) begin
                    p2_hit     = 1'b1;
                    p2_idx     = idx;
                    p2_addr    = a[idx];
                    p2_data    = d[idx];
                    gnt_c[idx] = 1'b1;
                end
            end
        end
        last = p2_hit ? p2_idx : p1_idx;
        if (p1_hit) begin
            ptr_d = rr_idx(last, 2'd1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Write stage; unused ports register address 0 / data 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr1_addr_q <= '0;
            wr1_data_q <= '0;
            wr2_addr_q <= '0;
            wr2_data_q <= '0;
        end else begin
            wr1_addr_q <= p1_hit ? p1_addr : '0;
            wr1_data_q <= p1_hit ? p1_data : '0;
            wr2_addr_q <= p2_hit ? p2_addr : '0;
            wr2_data_q <= p2_hit ? p2_data : '0;
        end
    end

    assign bus.req_ready = gnt_c | null_c;
    assign bus.wr1_addr  = wr1_addr_q;
    assign bus.wr1_data  = wr1_data_q;
    assign bus.wr2_addr  = wr2_addr_q;
    assign bus.wr2_data  = wr2_data_q;

`ifdef RF_WB_SB_EN
    localparam int unsigned n_regs = 1 << addr_w;

    logic [n_regs-1:0] busy_q;
    logic [n_regs-1:0] busy_d;

    // Clears from this cycle's grants, then issue set so that set wins.
    always_comb begin
        busy_d = busy_q;
        if (p1_hit) begin
            busy_d[p1_addr] = 1'b0;
        end
        if (p2_hit) begin
            busy_d[p2_addr] = 1'b0;
        end
        if (bus.iss_valid && (bus.iss_addr != '0)) begin
            busy_d[bus.iss_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign bus.rs1_busy = busy_q[bus.rs1_addr];
    assign bus.rs2_busy = busy_q[bus.rs2_addr];
`else
    logic unused_sb_inputs;
    assign unused_sb_inputs = ^{bus.iss_valid, bus.iss_addr, bus.rs1_addr, bus.rs2_addr};

    assign bus.rs1_busy = 1'b0;
    assign bus.rs2_busy = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed self-checking bench for rf_wb_sched: reset, three-way contention,
// same-address conflict, null writes, scoreboard set/clear and reset mid-op.
module tb_rf_wb_sched;
    localparam int unsigned addr_w = 5;
    localparam int unsigned data_w = 32;

`ifdef RF_WB_SB_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    localparam logic [31:0] DA = 32'hAAAA_0001;
    localparam logic [31:0] DB = 32'hBBBB_0002;
    localparam logic [31:0] DC = 32'hCCCC_0003;
    localparam logic [31:0] D0 = 32'h1111_0050;
    localparam logic [31:0] D1 = 32'h2222_0051;
    localparam logic [31:0] D2 = 32'h3333_0062;
    localparam logic [31:0] D7 = 32'h7777_0007;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    rf_wb_sched_if #(.addr_w(addr_w), .data_w(data_w)) bus ();

    rf_wb_sched #(.addr_w(addr_w), .data_w(data_w)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] v,
                         input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        bus.req_valid = v;
        bus.req_addr  = {a2, a1, a0};
        bus.req_data  = {d2, d1, d0};
    endtask

    task automatic chk_wr(input string tag, input logic [4:0] a1, input logic [31:0] dd1,
                          input logic [4:0] a2, input logic [31:0] dd2);
        chk({tag, "_wr1_addr"}, 32'(bus.wr1_addr), 32'(a1));
        chk({tag, "_wr1_data"}, bus.wr1_data, dd1);
        chk({tag, "_wr2_addr"}, 32'(bus.wr2_addr), 32'(a2));
        chk({tag, "_wr2_data"}, bus.wr2_data, dd2);
    endtask

    initial begin
        // Reset held two cycles with all requesters valid.
        rst           = 1'b1;
        bus.iss_valid = 1'b0;
        bus.iss_addr  = '0;
        bus.rs1_addr  = 5'd7;
        bus.rs2_addr  = 5'd0;
        drive(3'b111, 5'd1, 5'd2, 5'd3, DA, DB, DC);
        tick();
        tick();
        chk_wr("reset", 5'd0, 32'h0, 5'd0, 32'h0);
        chk("reset_rs1_busy", 32'(bus.rs1_busy), 32'h0);

        // Three-way contention: grants {0,1}, {2,0}, {1,2}.
        rst = 1'b0;
        #1;
        chk("cont1_ready", 32'(bus.req_ready), 32'h3);
        tick();
        chk_wr("cont1", 5'd1, DA, 5'd2, DB);
        #1;
        chk("cont2_ready", 32'(bus.req_ready), 32'h5);
        tick();
        chk_wr("cont2", 5'd3, DC, 5'd1, DA);
        #1;
        chk("cont3_ready", 32'(bus.req_ready), 32'h6);
        tick();
        chk_wr("cont3", 5'd2, DB, 5'd3, DC);

        // Same-address conflict with ptr back at 0.
        drive(3'b111, 5'd5, 5'd5, 5'd6, D0, D1, D2);
        #1;
        chk("same_ready", 32'(bus.req_ready), 32'h5);
        tick();
        chk_wr("same", 5'd5, D0, 5'd6, D2);
        drive(3'b010, 5'd5, 5'd5, 5'd6, D0, D1, D2);
        #1;
        chk("stall_ready", 32'(bus.req_ready), 32'h2);
        tick();
        chk_wr("stall", 5'd5, D1, 5'd0, 32'h0);

        // Null write: granted at once, no port use, ptr stays at 2.
        drive(3'b010, 5'd1, 5'd0, 5'd3, DA, DB, DC);
        #1;
        chk("null_ready", 32'(bus.req_ready), 32'h2);
        tick();
        chk("null_wr1_addr", 32'(bus.wr1_addr), 32'h0);
        chk("null_wr2_addr", 32'(bus.wr2_addr), 32'h0);
        drive(3'b111, 5'd1, 5'd2, 5'd3, DA, DB, DC);
        #1;
        chk("ptr_kept_ready", 32'(bus.req_ready), 32'h5);
        tick();
        chk_wr("ptr_kept", 5'd3, DC, 5'd1, DA);

        // Scoreboard: issue to 7, then retire a write-back to 7.
        drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        bus.iss_valid = 1'b1;
        bus.iss_addr  = 5'd7;
        #1;
        chk("sb_pre_set", 32'(bus.rs1_busy), 32'h0);
        tick();
        bus.iss_valid = 1'b0;
        chk("sb_set", 32'(bus.rs1_busy), 32'(SB));
        chk("sb_rs2_zero", 32'(bus.rs2_busy), 32'h0);
        drive(3'b001, 5'd7, 5'd0, 5'd0, D7, 32'h0, 32'h0);
        #1;
        chk("sb_clr_ready", 32'(bus.req_ready), 32'h1);
        chk("sb_before_clr", 32'(bus.rs1_busy), 32'(SB));
        tick();
        chk("sb_clr", 32'(bus.rs1_busy), 32'h0);
        chk("sb_clr_wr1_addr", 32'(bus.wr1_addr), 32'h7);

        // Set and clear of the same address in one cycle: set wins.
        drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        bus.iss_valid = 1'b1;
        tick();
        chk("sb_reset_again", 32'(bus.rs1_busy), 32'(SB));
        drive(3'b001, 5'd7, 5'd0, 5'd0, D7, 32'h0, 32'h0);
        tick();
        bus.iss_valid = 1'b0;
        chk("sb_set_wins", 32'(bus.rs1_busy), 32'(SB));
        chk("sb_set_wins_wr1", 32'(bus.wr1_addr), 32'h7);
        tick();
        chk("sb_final_clr", 32'(bus.rs1_busy), 32'h0);

        // Reset mid-operation discards the in-flight write and busy bits.
        drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        bus.iss_valid = 1'b1;
        tick();
        bus.iss_valid = 1'b0;
        chk("mid_set", 32'(bus.rs1_busy), 32'(SB));
        drive(3'b001, 5'd9, 5'd0, 5'd0, D0, 32'h0, 32'h0);
        rst = 1'b1;
        tick();
        chk_wr("mid_rst", 5'd0, 32'h0, 5'd0, 32'h0);
        chk("mid_rst_busy", 32'(bus.rs1_busy), 32'h0);
        rst = 1'b0;
        drive(3'b111, 5'd1, 5'd2, 5'd3, DA, DB, DC);
        #1;
        chk("mid_rst_ptr", 32'(bus.req_ready), 32'h3);
        tick();
        chk_wr("post_rst", 5'd1, DA, 5'd2, DB);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
